// File: rtl/led_pkg.sv
// Shared sizing helpers, bit-order mapping and state encodings for the LED frame sequencer.
package led_pkg;

   // Frame width in bits: 24 bits (GRB/RGB) per LED.
   function automatic int calc_fw(input int led_cnt);
      return led_cnt * 24;
   endfunction

   // Frame length in bytes: 3 bytes per LED.
   function automatic int calc_nb(input int led_cnt);
      return led_cnt * 3;
   endfunction

   // Latch gap in clock cycles.
   function automatic int calc_latch_cycles(input int clk_speed, input int latch_us);
      return clk_speed / 1_000_000 * latch_us;
   endfunction

   // I2C delivers MSB first; the driver shifts the frame LSB first, so each byte is mirrored.
   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) r[j] = b[7-j];
      return r;
   endfunction

   typedef enum logic [1:0] {
      TX_READY = 2'd0,
      TX_REQ   = 2'd1,
      TX_SEND  = 2'd2,
      TX_LATCH = 2'd3
   } tx_state_e;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_RECV = 1'b1
   } rx_state_e;

endpackage

// File: rtl/led_latch_timer.sv
// Saturating up-counter that measures the LED latch gap; expired once it reaches CYCLES.
module led_latch_timer #(
   parameter int CYCLES = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   output logic expired_o
);
   localparam int W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
   localparam logic [W-1:0] LIMIT = W'(CYCLES);

   logic [W-1:0] cnt_d, cnt_q;

   // Load restarts the gap; otherwise count up and hold at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)             cnt_d = '0;
      else if (cnt_q != LIMIT) cnt_d = cnt_q + W'(1);
   end

   // Out of reset the gap counts as already elapsed.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= LIMIT;
      else       cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/led_frame_ctrl.sv
// Frame sequencer: collects an I2C write into a shadow buffer, commits it on STOP and
// hands it to the serial LED driver through req/ack while honouring the latch gap.
module led_frame_ctrl
   import led_pkg::*;
#(
   parameter  int LED_CNT   = 3,
   parameter  int CLK_SPEED = 25_000_000,
   parameter  int LATCH_US  = 50,
   localparam int FW        = calc_fw(LED_CNT),
   localparam int NB        = calc_nb(LED_CNT),
   localparam int CW        = $clog2(NB + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    byte_i,
   input  logic          byte_valid_i,
   input  logic          start_i,
   input  logic          stop_i,
   output logic [FW-1:0] frame_o,
   output logic          frame_req_o,
   input  logic          frame_ack_i,
   input  logic          busy_i,
   output logic [CW-1:0] byte_cnt_o,
   output logic          overflow_o,
   output logic          pending_o
);
   localparam int LATCH_CYCLES = calc_latch_cycles(CLK_SPEED, LATCH_US);
   localparam int IW = $clog2(FW);
   localparam logic [CW-1:0] NB_C = CW'(NB);

   // RX side
   rx_state_e     rx_state_d, rx_state_q;
   logic [CW-1:0] byte_cnt_d, byte_cnt_q;
   logic          ovf_d, ovf_q;
   logic [FW-1:0] shadow_d, shadow_q;
   logic          commit_d, commit_q;
   logic [IW-1:0] wr_base;

   // TX side
   tx_state_e     tx_state_d, tx_state_q;
   logic [FW-1:0] frame_d, frame_q;
   logic          req_d, req_q;
   logic          pending_d, pending_q;
   logic          tmr_load;
   logic          tmr_expired;

   assign wr_base = IW'({byte_cnt_q, 3'b000});

   // Receive FSM: same-cycle events apply in the order byte, stop, start.
   always_comb begin
      rx_state_d = rx_state_q;
      byte_cnt_d = byte_cnt_q;
      ovf_d      = ovf_q;
      shadow_d   = shadow_q;
      commit_d   = 1'b0;
      if (rx_state_q == RX_IDLE) begin
         if (start_i) begin
            rx_state_d = RX_RECV;
            byte_cnt_d = '0;
            ovf_d      = 1'b0;
         end
      end else begin
         if (byte_valid_i) begin
            if (byte_cnt_q != NB_C) begin
               shadow_d[wr_base +: 8] = bit_rev8(byte_i);
               byte_cnt_d             = byte_cnt_q + CW'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end
         if (stop_i) begin
            commit_d   = (byte_cnt_d != '0);
            rx_state_d = RX_IDLE;
         end
         if (start_i) begin
            rx_state_d = RX_RECV;
            byte_cnt_d = '0;
            ovf_d      = 1'b0;
         end
      end
   end

   // Receive state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         byte_cnt_q <= '0;
         ovf_q      <= 1'b0;
         shadow_q   <= '0;
         commit_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         byte_cnt_q <= byte_cnt_d;
         ovf_q      <= ovf_d;
         shadow_q   <= shadow_d;
         commit_q   <= commit_d;
      end
   end

   // Transmit FSM: one outstanding request; commits arriving meanwhile coalesce into pending.
   always_comb begin
      tx_state_d = tx_state_q;
      frame_d    = frame_q;
      req_d      = req_q;
      pending_d  = pending_q;
      tmr_load   = 1'b0;
      case (tx_state_q)
         TX_READY: begin
            if ((commit_q || pending_q) && tmr_expired && !busy_i) begin
               frame_d    = shadow_d;
               req_d      = 1'b1;
               pending_d  = 1'b0;
               tx_state_d = TX_REQ;
            end else if (commit_q) begin
               pending_d = 1'b1;
            end
         end
         TX_REQ: begin
            if (commit_q) pending_d = 1'b1;
            if (frame_ack_i) begin
               req_d      = 1'b0;
               tx_state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (commit_q) pending_d = 1'b1;
            if (!busy_i) begin
               tmr_load   = 1'b1;
               tx_state_d = TX_LATCH;
            end
         end
         TX_LATCH: begin
            if (commit_q) pending_d = 1'b1;
            if (tmr_expired) tx_state_d = TX_READY;
         end
         default: tx_state_d = TX_READY;
      endcase
   end

   // Transmit state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= TX_READY;
         frame_q    <= '0;
         req_q      <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         frame_q    <= frame_d;
         req_q      <= req_d;
         pending_q  <= pending_d;
      end
   end

   led_latch_timer #(
      .CYCLES (LATCH_CYCLES)
   ) u_latch_timer (
      .clk       (clk),
      .reset     (reset),
      .load_i    (tmr_load),
      .expired_o (tmr_expired)
   );

   assign frame_o     = frame_q;
   assign frame_req_o = req_q;
   assign byte_cnt_o  = byte_cnt_q;
   assign overflow_o  = ovf_q;
   assign pending_o   = pending_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl with a simple req/ack/busy driver model.
module tb_led_frame_ctrl;
   localparam int FW = 72;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    byte_i = 8'h00;
   logic          byte_valid_i = 1'b0;
   logic          start_i = 1'b0;
   logic          stop_i = 1'b0;
   logic [FW-1:0] frame_o;
   logic          frame_req_o;
   logic          frame_ack_i = 1'b0;
   logic          busy_i = 1'b0;
   logic [CW-1:0] byte_cnt_o;
   logic          overflow_o;
   logic          pending_o;

   int checks = 0;
   int errors = 0;

   // driver model state
   int            busy_cnt = 0;
   int            req_age = 0;
   int            req_count = 0;
   int            cyc_cnt = 0;
   int            req_rise_cyc = 0;
   int            busy_fall_cyc = 0;
   logic [FW-1:0] last_frame = '0;

   always #5 clk = ~clk;

   led_frame_ctrl #(
      .LED_CNT   (3),
      .CLK_SPEED (1_000_000),
      .LATCH_US  (10)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .start_i      (start_i),
      .stop_i       (stop_i),
      .frame_o      (frame_o),
      .frame_req_o  (frame_req_o),
      .frame_ack_i  (frame_ack_i),
      .busy_i       (busy_i),
      .byte_cnt_o   (byte_cnt_o),
      .overflow_o   (overflow_o),
      .pending_o    (pending_o)
   );

   always @(posedge clk) cyc_cnt++;

   // Driver: acks two cycles after req rises, then stays busy for 20 cycles.
   always @(negedge clk) begin
      frame_ack_i = 1'b0;
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            busy_i        = 1'b0;
            busy_fall_cyc = cyc_cnt;
         end
      end
      if (frame_req_o && !reset) begin
         if (req_age == 0) req_rise_cyc = cyc_cnt;
         req_age++;
         if (req_age == 2) begin
            frame_ack_i = 1'b1;
            busy_i      = 1'b1;
            busy_cnt    = 20;
            req_age     = 0;
            req_count++;
            last_frame  = frame_o;
         end
      end else begin
         req_age = 0;
      end
   end

   typedef struct packed {
      logic [3:0]    n;
      logic [79:0]   bytes;
      logic [FW-1:0] frame;
      logic [3:0]    cnt;
      logic          ovf;
      logic          nreq;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Drive one cycle worth of receiver strobes.
   task automatic cyc(input logic s, input logic bv, input logic [7:0] b, input logic p);
      @(negedge clk);
      start_i      = s;
      byte_valid_i = bv;
      byte_i       = b;
      stop_i       = p;
   endtask

   task automatic wait_req(input int target, input string name);
      int n = 0;
      while (req_count < target && n < 200) begin
         tick();
         n++;
      end
      chk(name, 72'(req_count), 72'(target));
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((frame_req_o || busy_i || pending_o) && n < 300) begin
         tick();
         n++;
      end
      chk(name, 72'(frame_req_o || busy_i || pending_o), 72'(0));
      repeat (15) tick();
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      int rc0;
      rc0 = req_count;
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < int'(v.n); i++) cyc(1'b0, 1'b1, v.bytes[8*i +: 8], 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      if (v.nreq) wait_req(rc0 + 1, $sformatf("vec%0d_req", idx));
      wait_idle($sformatf("vec%0d_idle", idx));
      chk($sformatf("vec%0d_frame", idx), frame_o, v.frame);
      chk($sformatf("vec%0d_cnt", idx), 72'(byte_cnt_o), 72'(v.cnt));
      chk($sformatf("vec%0d_ovf", idx), 72'(overflow_o), 72'(v.ovf));
      chk($sformatf("vec%0d_nreq", idx), 72'(req_count - rc0), 72'(v.nreq));
      if (v.nreq) chk($sformatf("vec%0d_sent", idx), last_frame, v.frame);
   endtask

   initial begin
      int rc0;
      vecs[0] = '{n: 4'd9,  bytes: 80'h00_09_08_07_06_05_04_03_02_01,
                  frame: 72'h90_10_E0_60_A0_20_C0_40_80, cnt: 4'd9, ovf: 1'b0, nreq: 1'b1};
      vecs[1] = '{n: 4'd10, bytes: 80'h1A_19_18_17_16_15_14_13_12_11,
                  frame: 72'h98_18_E8_68_A8_28_C8_48_88, cnt: 4'd9, ovf: 1'b1, nreq: 1'b1};
      vecs[2] = '{n: 4'd0,  bytes: 80'h0,
                  frame: 72'h98_18_E8_68_A8_28_C8_48_88, cnt: 4'd0, ovf: 1'b0, nreq: 1'b0};
      vecs[3] = '{n: 4'd2,  bytes: 80'h00_00_00_00_00_00_00_00_01_FF,
                  frame: 72'h98_18_E8_68_A8_28_C8_80_FF, cnt: 4'd2, ovf: 1'b0, nreq: 1'b1};

      // reset state
      reset = 1'b1;
      repeat (2) tick();
      chk("rst_frame", frame_o, 72'h0);
      chk("rst_req", 72'(frame_req_o), 72'(0));
      chk("rst_cnt", 72'(byte_cnt_o), 72'(0));
      chk("rst_ovf", 72'(overflow_o), 72'(0));
      chk("rst_pend", 72'(pending_o), 72'(0));
      reset = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) apply_vec(vecs[i], i);

      // byte+stop in the same cycle; request appears two cycles after stop
      rc0 = req_count;
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h01, 1'b0);
      cyc(1'b0, 1'b1, 8'h02, 1'b0);
      cyc(1'b0, 1'b1, 8'h03, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("lat_t1_req", 72'(frame_req_o), 72'(0));
      tick();
      chk("lat_t2_req", 72'(frame_req_o), 72'(1));
      chk("lat_t2_frame", frame_o, 72'h98_18_E8_68_A8_28_C0_40_80);
      wait_req(rc0 + 1, "bs_req");
      wait_idle("bs_idle");
      chk("bs_cnt", 72'(byte_cnt_o), 72'(3));
      chk("bs_nreq", 72'(req_count - rc0), 72'(1));

      // repeated start: shadow byte 1 survives, byte 0 overwritten
      rc0 = req_count;
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'hAA, 1'b0);
      cyc(1'b0, 1'b1, 8'hBB, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'hCC, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      wait_req(rc0 + 1, "rs_req");
      wait_idle("rs_idle");
      chk("rs_frame", last_frame, 72'h98_18_E8_68_A8_28_C0_DD_33);
      chk("rs_cnt", 72'(byte_cnt_o), 72'(1));
      chk("rs_nreq", 72'(req_count - rc0), 72'(1));

      // coalescing: two commits while the driver is busy produce one more request
      rc0 = req_count;
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h01, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      wait_req(rc0 + 1, "co_a_req");
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h55, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("co_b_pend", 72'(pending_o), 72'(1));
      repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h0F, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk("co_c_pend", 72'(pending_o), 72'(1));
      chk("co_c_noreq", 72'(req_count - rc0), 72'(1));
      chk("co_busy", 72'(busy_i), 72'(1));
      wait_req(rc0 + 2, "co_req2");
      chk("co_frame", last_frame, 72'h98_18_E8_68_A8_28_C0_DD_F0);
      if (req_rise_cyc - busy_fall_cyc < 10)
         $display("FAIL co_gap actual=%0d required>=10", req_rise_cyc - busy_fall_cyc);
      chk("co_gap_ok", 72'(req_rise_cyc - busy_fall_cyc >= 10), 72'(1));
      repeat (60) tick();
      chk("co_once", 72'(req_count - rc0), 72'(2));
      chk("co_pend_clr", 72'(pending_o), 72'(0));

      // reset in the middle of a transaction
      rc0 = req_count;
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'h11, 1'b0);
      cyc(1'b0, 1'b1, 8'h22, 1'b0);
      cyc(1'b0, 1'b1, 8'h33, 1'b0);
      cyc(1'b0, 1'b1, 8'h44, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      chk("mr_frame", frame_o, 72'h0);
      chk("mr_cnt", 72'(byte_cnt_o), 72'(0));
      chk("mr_ovf", 72'(overflow_o), 72'(0));
      chk("mr_pend", 72'(pending_o), 72'(0));
      reset = 1'b0;
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      repeat (30) tick();
      chk("mr_noreq", 72'(req_count - rc0), 72'(0));
      chk("mr_req_lo", 72'(frame_req_o), 72'(0));
      apply_vec(vecs[0], 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
